// File: rtl/ex_unit_mc.sv
// Multi-cycle execute stage: single-cycle ALU/branch resolution plus an
// iterative shift-add multiplier and restoring divider behind valid/ready.
module ex_unit_mc #(
  parameter int XLEN      = 32,
  parameter int IMM_SHIFT = 1,
  parameter bit MULDIV_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_cpu_n,
  input  logic            kill,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [XLEN-1:0] imm,
  input  logic            rs2_sel,
  input  logic [3:0]      alu_op,
  input  logic [3:0]      br_type,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_res,
  output logic [XLEN-1:0] out_target,
  output logic            out_flush,
  output logic            out_pc_sel,
  output logic            out_npc_sel,
  output logic            busy
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_FIX} state_t;

  state_t          state;
  logic [CW-1:0]   count;
  logic [3:0]      op_q;
  logic            neg_q, neg_r, spec_q;
  logic [XLEN-1:0] acc_hi, acc_lo, b_q;

  logic [XLEN-1:0] op2, alu_res, target, link, fix_res;
  logic [XLEN-1:0] a_abs, b_abs, spec_val;
  logic [CW-1:0]   shamt;
  logic            is_md, sgn, a_neg, b_neg, div0, ovf;
  logic            br_eq, br_lt, br_ltu, taken, is_jalr;
  logic [XLEN:0]   mul_sum, div_rs, div_trial;

  assign in_ready = (state == S_IDLE) & ~kill & (~out_valid | out_ready);
  assign busy     = (state != S_IDLE);

  assign op2   = rs2_sel ? imm : rs2;
  assign shamt = op2[CW-1:0];
  assign is_md = (alu_op >= 4'd10);

  always_comb begin
    alu_res = '0;
    case (alu_op)
      4'd0: alu_res = rs1 + op2;
      4'd1: alu_res = rs1 - op2;
      4'd2: alu_res = rs1 & op2;
      4'd3: alu_res = rs1 | op2;
      4'd4: alu_res = rs1 ^ op2;
      4'd5: alu_res = rs1 << shamt;
      4'd6: alu_res = rs1 >> shamt;
      4'd7: alu_res = $signed(rs1) >>> shamt;
      4'd8: alu_res = {{(XLEN-1){1'b0}}, $signed(rs1) < $signed(op2)};
      4'd9: alu_res = {{(XLEN-1){1'b0}}, rs1 < op2};
      default: alu_res = '0;
    endcase
  end

  // Branch compare is always register-to-register, independent of rs2_sel.
  assign br_eq   = (rs1 == rs2);
  assign br_lt   = $signed(rs1) < $signed(rs2);
  assign br_ltu  = rs1 < rs2;
  assign is_jalr = (br_type == 4'd6);
  assign link    = pc + XLEN'(4);
  assign target  = is_jalr ? ((rs1 + imm) & ~XLEN'(1)) : (pc + (imm << IMM_SHIFT));

  always_comb begin
    taken = 1'b0;
    case (br_type)
      4'd1: taken = br_eq;
      4'd2: taken = ~br_eq;
      4'd3: taken = ~br_lt;
      4'd4: taken = br_lt;
      4'd5: taken = 1'b1;
      4'd7: taken = br_ltu;
      4'd8: taken = ~br_ltu;
      default: taken = 1'b0;
    endcase
  end

  // Even ops (mul, div, rem) are signed; odd ops are unsigned.
  assign sgn      = ~alu_op[0];
  assign a_neg    = sgn & rs1[XLEN-1];
  assign b_neg    = sgn & op2[XLEN-1];
  assign a_abs    = a_neg ? -rs1 : rs1;
  assign b_abs    = b_neg ? -op2 : op2;
  assign div0     = alu_op[2] & (op2 == '0);
  assign ovf      = alu_op[2] & sgn & (rs1 == MIN_VAL) & (op2 == '1);
  assign spec_val = div0 ? (alu_op[1] ? rs1 : '1) : (alu_op[1] ? '0 : MIN_VAL);

  assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, b_q} : '0);
  assign div_rs    = {acc_hi, acc_lo[XLEN-1]};
  assign div_trial = div_rs - {1'b0, b_q};

  always_comb begin
    fix_res = acc_lo;
    if (!spec_q) begin
      case (op_q)
        4'd10:   fix_res = neg_q ? -acc_lo : acc_lo;
        4'd11:   fix_res = acc_hi;
        4'd12:   fix_res = neg_q ? -acc_lo : acc_lo;
        4'd13:   fix_res = acc_lo;
        4'd14:   fix_res = neg_r ? -acc_hi : acc_hi;
        4'd15:   fix_res = acc_hi;
        default: fix_res = acc_lo;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_cpu_n) begin
    if (!rst_cpu_n) begin
      state       <= S_IDLE;
      count       <= '0;
      op_q        <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      spec_q      <= 1'b0;
      acc_hi      <= '0;
      acc_lo      <= '0;
      b_q         <= '0;
      out_valid   <= 1'b0;
      out_res     <= '0;
      out_target  <= '0;
      out_flush   <= 1'b0;
      out_pc_sel  <= 1'b0;
      out_npc_sel <= 1'b0;
    end else if (kill) begin
      state       <= S_IDLE;
      out_valid   <= 1'b0;
      out_res     <= '0;
      out_target  <= '0;
      out_flush   <= 1'b0;
      out_pc_sel  <= 1'b0;
      out_npc_sel <= 1'b0;
    end else begin
      // Drain a consumed result; a new result written below takes precedence.
      if (out_ready) begin
        out_valid   <= 1'b0;
        out_res     <= '0;
        out_target  <= '0;
        out_flush   <= 1'b0;
        out_pc_sel  <= 1'b0;
        out_npc_sel <= 1'b0;
      end
      case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            if (MULDIV_EN && is_md) begin
              op_q   <= alu_op;
              neg_q  <= a_neg ^ b_neg;
              neg_r  <= a_neg;
              spec_q <= div0 | ovf;
              acc_hi <= '0;
              acc_lo <= (div0 | ovf) ? spec_val : a_abs;
              b_q    <= b_abs;
              count  <= CW'(XLEN - 1);
              state  <= (div0 | ovf) ? S_FIX : S_BUSY;
            end else begin
              out_valid   <= 1'b1;
              out_res     <= (br_type == 4'd5 || is_jalr) ? link : alu_res;
              out_target  <= target;
              out_flush   <= taken | is_jalr;
              out_pc_sel  <= is_jalr;
              out_npc_sel <= taken;
            end
          end
        end
        S_BUSY: begin
          if (!op_q[2]) begin
            {acc_hi, acc_lo} <= {mul_sum, acc_lo[XLEN-1:1]};
          end else if (!div_trial[XLEN]) begin
            acc_hi <= div_trial[XLEN-1:0];
            acc_lo <= {acc_lo[XLEN-2:0], 1'b1};
          end else begin
            acc_hi <= div_rs[XLEN-1:0];
            acc_lo <= {acc_lo[XLEN-2:0], 1'b0};
          end
          if (count == '0) state <= S_FIX;
          else             count <= count - 1'b1;
        end
        S_FIX: begin
          // Hold the finished result until the previous one has been taken.
          if (!out_valid || out_ready) begin
            out_valid   <= 1'b1;
            out_res     <= fix_res;
            out_target  <= '0;
            out_flush   <= 1'b0;
            out_pc_sel  <= 1'b0;
            out_npc_sel <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_unit_mc.sv
// Directed self-checking bench for ex_unit_mc (XLEN=32, IMM_SHIFT=1, MULDIV_EN=1).
module tb_ex_unit_mc;

  logic        clk;
  logic        rst_cpu_n;
  logic        kill;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] pc, rs1, rs2, imm;
  logic        rs2_sel;
  logic [3:0]  alu_op, br_type;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_res, out_target;
  logic        out_flush, out_pc_sel, out_npc_sel;
  logic        busy;

  int checks = 0;
  int errors = 0;

  ex_unit_mc #(.XLEN(32), .IMM_SHIFT(1), .MULDIV_EN(1'b1)) dut (
    .clk(clk), .rst_cpu_n(rst_cpu_n), .kill(kill),
    .in_valid(in_valid), .in_ready(in_ready),
    .pc(pc), .rs1(rs1), .rs2(rs2), .imm(imm), .rs2_sel(rs2_sel),
    .alu_op(alu_op), .br_type(br_type),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_res(out_res), .out_target(out_target), .out_flush(out_flush),
    .out_pc_sel(out_pc_sel), .out_npc_sel(out_npc_sel), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one op, let it be taken on the next edge, sample 1 time unit later.
  task automatic drive(input logic [3:0] op, input logic [3:0] br,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic sel, input logic [31:0] p, input logic [31:0] im);
    alu_op = op; br_type = br; rs1 = a; rs2_sel = sel; pc = p;
    rs2 = sel ? 32'h55 : b;
    imm = sel ? b : im;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Edges from accept to out_valid (accept edge counted), bounded.
  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    rst_cpu_n = 1'b0; kill = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    pc = '0; rs1 = '0; rs2 = '0; imm = '0; rs2_sel = 1'b0; alu_op = '0; br_type = '0;
    #12;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (out_res !== 32'h0) begin errors++; $display("FAIL reset_out_res got %h want 0", out_res); end
    checks++; if (out_flush !== 1'b0) begin errors++; $display("FAIL reset_out_flush got %b want 0", out_flush); end
    rst_cpu_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
  endtask

  // Consecutive ops, one per cycle, with out_ready held high.
  task automatic test_back_to_back;
    logic [3:0]  ops [12];
    logic [31:0] av  [12];
    logic [31:0] bv  [12];
    logic        sv  [12];
    logic [31:0] ev  [12];
    ops[0]=4'd0;  av[0]=32'd5;        bv[0]=32'hFFFFFFFD; sv[0]=1; ev[0]=32'd2;
    ops[1]=4'd1;  av[1]=32'd3;        bv[1]=32'd5;        sv[1]=0; ev[1]=32'hFFFFFFFE;
    ops[2]=4'd2;  av[2]=32'hF0F01234; bv[2]=32'h0FF0FF00; sv[2]=0; ev[2]=32'h00F01200;
    ops[3]=4'd3;  av[3]=32'hF0000000; bv[3]=32'h0000000F; sv[3]=1; ev[3]=32'hF000000F;
    ops[4]=4'd4;  av[4]=32'hFFFF0000; bv[4]=32'h0F0F0F0F; sv[4]=0; ev[4]=32'hF0F00F0F;
    ops[5]=4'd5;  av[5]=32'd1;        bv[5]=32'h21;       sv[5]=1; ev[5]=32'd2;
    ops[6]=4'd6;  av[6]=32'h80000000; bv[6]=32'd31;       sv[6]=0; ev[6]=32'd1;
    ops[7]=4'd7;  av[7]=32'h80000000; bv[7]=32'd4;        sv[7]=0; ev[7]=32'hF8000000;
    ops[8]=4'd8;  av[8]=32'hFFFFFFFF; bv[8]=32'd1;        sv[8]=0; ev[8]=32'd1;
    ops[9]=4'd9;  av[9]=32'hFFFFFFFF; bv[9]=32'd1;        sv[9]=0; ev[9]=32'd0;
    ops[10]=4'd8; av[10]=32'h80000000; bv[10]=32'h7FFFFFFF; sv[10]=0; ev[10]=32'd1;
    ops[11]=4'd0; av[11]=32'hFFFFFFFF; bv[11]=32'd1;      sv[11]=0; ev[11]=32'd0;
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready[%0d] got %b want 1", i, in_ready); end
      drive(ops[i], 4'd0, av[i], bv[i], sv[i], 32'h0, 32'h0);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d] got %b want 1", i, out_valid); end
      checks++; if (out_res !== ev[i]) begin errors++; $display("FAIL b2b_res[%0d] op=%0d got %h want %h", i, ops[i], out_res, ev[i]); end
      checks++; if (out_flush !== 1'b0) begin errors++; $display("FAIL b2b_flush[%0d] got %b want 0", i, out_flush); end
    end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b want 0", out_valid); end
  endtask

  task automatic test_branch;
    drive(4'd0, 4'd7, 32'd1, 32'hFFFFFFFF, 1'b0, 32'h100, 32'd8);
    checks++; if (out_npc_sel !== 1'b1) begin errors++; $display("FAIL bltu_npc got %b want 1", out_npc_sel); end
    checks++; if (out_target !== 32'h110) begin errors++; $display("FAIL bltu_target got %h want 110", out_target); end
    checks++; if ({out_flush, out_pc_sel} !== 2'b10) begin errors++; $display("FAIL bltu_flags got %b want 10", {out_flush, out_pc_sel}); end
    drive(4'd0, 4'd4, 32'd1, 32'hFFFFFFFF, 1'b0, 32'h100, 32'd8);
    checks++; if ({out_flush, out_pc_sel, out_npc_sel} !== 3'b000) begin errors++; $display("FAIL blt_flags got %b want 000", {out_flush, out_pc_sel, out_npc_sel}); end
    drive(4'd0, 4'd6, 32'h1003, 32'd4, 1'b1, 32'h40, 32'd0);
    checks++; if (out_res !== 32'h44) begin errors++; $display("FAIL jalr_res got %h want 44", out_res); end
    checks++; if (out_target !== 32'h1006) begin errors++; $display("FAIL jalr_target got %h want 1006", out_target); end
    checks++; if ({out_flush, out_pc_sel, out_npc_sel} !== 3'b110) begin errors++; $display("FAIL jalr_flags got %b want 110", {out_flush, out_pc_sel, out_npc_sel}); end
    drive(4'd0, 4'd5, 32'd0, 32'd0, 1'b0, 32'h200, 32'h10);
    checks++; if ({out_res, out_target} !== {32'h204, 32'h220}) begin errors++; $display("FAIL jal_res_target got %h/%h want 204/220", out_res, out_target); end
    checks++; if ({out_flush, out_pc_sel, out_npc_sel} !== 3'b101) begin errors++; $display("FAIL jal_flags got %b want 101", {out_flush, out_pc_sel, out_npc_sel}); end
    drive(4'd0, 4'd1, 32'd7, 32'd7, 1'b0, 32'h300, 32'h4);
    checks++; if ({out_npc_sel, out_target} !== {1'b1, 32'h308}) begin errors++; $display("FAIL beq_taken got %b/%h want 1/308", out_npc_sel, out_target); end
    // Immediate equals rs1 but the compare must still use rs2.
    drive(4'd0, 4'd1, 32'd5, 32'd5, 1'b1, 32'h300, 32'h0);
    checks++; if (out_npc_sel !== 1'b0) begin errors++; $display("FAIL beq_uses_rs2 got %b want 0", out_npc_sel); end
    drive(4'd0, 4'd3, 32'hFFFFFFFF, 32'd1, 1'b0, 32'h0, 32'h4);
    checks++; if (out_flush !== 1'b0) begin errors++; $display("FAIL bge_signed got %b want 0", out_flush); end
    drive(4'd0, 4'd8, 32'hFFFFFFFF, 32'd1, 1'b0, 32'h0, 32'h4);
    checks++; if (out_flush !== 1'b1) begin errors++; $display("FAIL bgeu got %b want 1", out_flush); end
    @(posedge clk); #1;
  endtask

  task automatic test_div;
    int lat, nb, rdy_bad;
    out_ready = 1'b1;
    drive(4'd12, 4'd0, 32'hFFFFFFF9, 32'd2, 1'b0, 32'h0, 32'h0);
    lat = 1; nb = 0; rdy_bad = 0;
    while (!out_valid && lat < 100) begin
      if (busy) nb++;
      if (in_ready) rdy_bad++;
      @(posedge clk); #1;
      lat++;
    end
    checks++; if (lat !== 34) begin errors++; $display("FAIL div_latency got %0d want 34", lat); end
    checks++; if (nb !== 33) begin errors++; $display("FAIL div_busy_cycles got %0d want 33", nb); end
    checks++; if (rdy_bad !== 0) begin errors++; $display("FAIL div_in_ready_while_busy got %0d want 0", rdy_bad); end
    checks++; if (out_res !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_m7_2 got %h want fffffffd", out_res); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL div_busy_after got %b want 0", busy); end
    drive(4'd14, 4'd0, 32'hFFFFFFF9, 32'd2, 1'b0, 32'h0, 32'h0); wait_out(lat);
    checks++; if (out_res !== 32'hFFFFFFFF) begin errors++; $display("FAIL rem_m7_2 got %h want ffffffff", out_res); end
    drive(4'd14, 4'd0, 32'd7, 32'hFFFFFFFE, 1'b0, 32'h0, 32'h0); wait_out(lat);
    checks++; if (out_res !== 32'd1) begin errors++; $display("FAIL rem_7_m2 got %h want 1", out_res); end
    drive(4'd12, 4'd0, 32'd7, 32'hFFFFFFFE, 1'b0, 32'h0, 32'h0); wait_out(lat);
    checks++; if (out_res !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_7_m2 got %h want fffffffd", out_res); end
    drive(4'd13, 4'd0, 32'd100, 32'd7, 1'b0, 32'h0, 32'h0); wait_out(lat);
    checks++; if (out_res !== 32'd14) begin errors++; $display("FAIL divu_100_7 got %h want e", out_res); end
    drive(4'd15, 4'd0, 32'd100, 32'd7, 1'b1, 32'h0, 32'h0); wait_out(lat);
    checks++; if (out_res !== 32'd2) begin errors++; $display("FAIL remu_100_7 got %h want 2", out_res); end
    drive(4'd13, 4'd0, 32'd5, 32'd0, 1'b0, 32'h0, 32'h0); wait_out(lat);
    checks++; if ({lat, out_res} !== {32'd2, 32'hFFFFFFFF}) begin errors++; $display("FAIL divu_by0 got lat %0d res %h want 2/ffffffff", lat, out_res); end
    drive(4'd15, 4'd0, 32'd5, 32'd0, 1'b0, 32'h0, 32'h0); wait_out(lat);
    checks++; if ({lat, out_res} !== {32'd2, 32'd5}) begin errors++; $display("FAIL remu_by0 got lat %0d res %h want 2/5", lat, out_res); end
    drive(4'd12, 4'd0, 32'hFFFFFFFB, 32'd0, 1'b0, 32'h0, 32'h0); wait_out(lat);
    checks++; if (out_res !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_by0 got %h want ffffffff", out_res); end
    drive(4'd12, 4'd0, 32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h0, 32'h0); wait_out(lat);
    checks++; if ({lat, out_res} !== {32'd2, 32'h80000000}) begin errors++; $display("FAIL div_ovf got lat %0d res %h want 2/80000000", lat, out_res); end
    drive(4'd14, 4'd0, 32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h0, 32'h0); wait_out(lat);
    checks++; if (out_res !== 32'h0) begin errors++; $display("FAIL rem_ovf got %h want 0", out_res); end
    @(posedge clk); #1;
  endtask

  task automatic test_mul;
    int lat;
    out_ready = 1'b1;
    drive(4'd11, 4'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h0, 32'h0); wait_out(lat);
    checks++; if (lat !== 34) begin errors++; $display("FAIL mulhu_latency got %0d want 34", lat); end
    checks++; if (out_res !== 32'hFFFFFFFE) begin errors++; $display("FAIL mulhu got %h want fffffffe", out_res); end
    drive(4'd10, 4'd0, 32'hFFFFFFFD, 32'd5, 1'b0, 32'h0, 32'h0); wait_out(lat);
    checks++; if (out_res !== 32'hFFFFFFF1) begin errors++; $display("FAIL mul_m3_5 got %h want fffffff1", out_res); end
    drive(4'd10, 4'd0, 32'h12345678, 32'h10, 1'b1, 32'h0, 32'h0); wait_out(lat);
    checks++; if (out_res !== 32'h23456780) begin errors++; $display("FAIL mul_imm got %h want 23456780", out_res); end
    @(posedge clk); #1;
  endtask

  task automatic test_kill;
    int seen;
    out_ready = 1'b1;
    drive(4'd13, 4'd0, 32'd100, 32'd3, 1'b0, 32'h0, 32'h0);
    repeat (9) begin @(posedge clk); #1; end
    kill = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL kill_in_ready got %b want 0", in_ready); end
    @(posedge clk); #1;
    kill = 1'b0;
    checks++; if ({busy, out_valid} !== 2'b00) begin errors++; $display("FAIL kill_busy_valid got %b want 00", {busy, out_valid}); end
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (out_valid) seen++; end
    checks++; if (seen !== 0) begin errors++; $display("FAIL kill_no_output got %0d want 0", seen); end
    out_ready = 1'b0;
    drive(4'd0, 4'd0, 32'd1, 32'd1, 1'b0, 32'h0, 32'h0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL kill_idle_pre got %b want 1", out_valid); end
    kill = 1'b1; in_valid = 1'b1; rs1 = 32'd2; rs2 = 32'd2;
    @(posedge clk); #1;
    kill = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL kill_idle_drop got %b want 0", out_valid); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL kill_no_accept got %b want 0", out_valid); end
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    drive(4'd0, 4'd0, 32'd1, 32'd2, 1'b0, 32'h0, 32'h0);
    alu_op = 4'd0; br_type = 4'd0; rs1 = 32'd10; rs2 = 32'd20; rs2_sel = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++; if ({out_valid, out_res, in_ready} !== {1'b1, 32'd3, 1'b0}) begin
        errors++; $display("FAIL stall[%0d] got v=%b res=%h rdy=%b want 1/3/0", i, out_valid, out_res, in_ready);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready got %b want 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if ({out_valid, out_res} !== {1'b1, 32'd30}) begin errors++; $display("FAIL stall_after got %b/%h want 1/1e", out_valid, out_res); end
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset;
    int seen;
    out_ready = 1'b1;
    drive(4'd11, 4'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h0, 32'h0);
    repeat (5) begin @(posedge clk); #1; end
    #2 rst_cpu_n = 1'b0;
    #1;
    checks++; if ({busy, out_valid, out_res} !== {1'b0, 1'b0, 32'h0}) begin
      errors++; $display("FAIL async_reset got busy=%b v=%b res=%h want 0/0/0", busy, out_valid, out_res);
    end
    #2 rst_cpu_n = 1'b1;
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (out_valid || busy) seen++; end
    checks++; if (seen !== 0) begin errors++; $display("FAIL async_reset_residual got %0d want 0", seen); end
  endtask

  initial begin
    test_reset;
    test_back_to_back;
    test_branch;
    test_div;
    test_mul;
    test_kill;
    test_backpressure;
    test_async_reset;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
